// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word alignment by bit-slip, token and data decode.
// Ports: clk_dot4x, rst_n, tmds_raw[9:0] -> data_out, ctrl_out, de, locked, bit_offset.
module tmds_channel_decoder #(
    parameter int TOKEN_RUN      = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int CNT_W          = 16
) (
    input  logic       clk_dot4x,
    input  logic       rst_n,
    input  logic [9:0] tmds_raw,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de,
    output logic       locked,
    output logic [3:0] bit_offset
);

    typedef enum logic [1:0] {
        SEARCH,
        SLIP,
        LOCKED
    } state_t;

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(TOKEN_RUN);
    localparam logic [CNT_W-1:0] STMR_MAX = CNT_W'(SEARCH_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(LOCK_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [9:0]       raw_prev;
    logic [9:0]       s1_word;
    logic [19:0]      window;
    logic [9:0]       aligned;
    logic [CNT_W-1:0] run, run_nxt;
    logic [CNT_W-1:0] search_tmr, stmr_nxt;
    logic [CNT_W-1:0] gap_tmr, gap_nxt;
    logic             slip_cnt, slip_nxt;
    logic [3:0]       off_nxt;
    logic [3:0]       off_inc;
    logic             is_tok;
    logic [1:0]       tok_code;
    logic [7:0]       d;
    logic [7:0]       q;
    logic             lock_nxt;

    // Older word sits in the low half, so offset 0 selects raw_prev.
    assign window  = {tmds_raw, raw_prev};
    assign aligned = 10'(window >> bit_offset);
    assign off_inc = (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;

    always_comb begin
        is_tok   = 1'b1;
        tok_code = 2'b00;
        unique case (1'b1)
            (s1_word == 10'h354): tok_code = 2'b00;
            (s1_word == 10'h0AB): tok_code = 2'b01;
            (s1_word == 10'h154): tok_code = 2'b10;
            (s1_word == 10'h2AB): tok_code = 2'b11;
            default:              is_tok   = 1'b0;
        endcase
    end

    always_comb begin
        d    = s1_word[9] ? ~s1_word[7:0] : s1_word[7:0];
        q    = 8'd0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = s1_word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        stmr_nxt  = search_tmr;
        gap_nxt   = gap_tmr;
        slip_nxt  = slip_cnt;
        off_nxt   = bit_offset;
        case (state)
            SEARCH: begin
                stmr_nxt = search_tmr + 1'b1;
                run_nxt  = is_tok ? run + 1'b1 : '0;
                if (is_tok && (run + 1'b1 == RUN_MAX)) begin
                    state_nxt = LOCKED;
                    gap_nxt   = '0;
                end else if (search_tmr == STMR_MAX) begin
                    state_nxt = SLIP;
                    slip_nxt  = 1'b0;
                    off_nxt   = off_inc;
                end
            end
            SLIP: begin
                // Two cycles let the new offset reach stage 1.
                if (slip_cnt) begin
                    state_nxt = SEARCH;
                    run_nxt   = '0;
                    stmr_nxt  = '0;
                end else begin
                    slip_nxt = 1'b1;
                end
            end
            LOCKED: begin
                if (is_tok) begin
                    gap_nxt = '0;
                end else if (gap_tmr == GAP_MAX) begin
                    state_nxt = SLIP;
                    slip_nxt  = 1'b0;
                    off_nxt   = off_inc;
                end else begin
                    gap_nxt = gap_tmr + 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    // Outputs follow the next state so locked rises with the final token.
    assign lock_nxt = (state_nxt == LOCKED);

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEARCH;
            raw_prev   <= '0;
            s1_word    <= '0;
            run        <= '0;
            search_tmr <= '0;
            gap_tmr    <= '0;
            slip_cnt   <= 1'b0;
            bit_offset <= '0;
            locked     <= 1'b0;
            de         <= 1'b0;
            ctrl_out   <= '0;
            data_out   <= '0;
        end else begin
            state      <= state_nxt;
            raw_prev   <= tmds_raw;
            s1_word    <= aligned;
            run        <= run_nxt;
            search_tmr <= stmr_nxt;
            gap_tmr    <= gap_nxt;
            slip_cnt   <= slip_nxt;
            bit_offset <= off_nxt;
            locked     <= lock_nxt;
            if (!lock_nxt) begin
                de       <= 1'b0;
                ctrl_out <= 2'b00;
                data_out <= 8'h00;
            end else if (is_tok) begin
                de       <= 1'b0;
                ctrl_out <= tok_code;
            end else begin
                de       <= 1'b1;
                data_out <= q;
            end
        end
    end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: lock, slip, decode, timeout, reset.
// Drives tmds_raw and checks data_out, ctrl_out, de, locked, bit_offset.
module tb_tmds_channel_decoder;

    logic       clk;
    logic       rst_n;
    logic [9:0] tmds_raw;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de;
    logic       locked;
    logic [3:0] bit_offset;

    int tests;
    int fails;

    tmds_channel_decoder #(
        .TOKEN_RUN     (8),
        .SEARCH_TIMEOUT(64),
        .LOCK_TIMEOUT  (128),
        .CNT_W         (16)
    ) dut (
        .clk_dot4x (clk),
        .rst_n     (rst_n),
        .tmds_raw  (tmds_raw),
        .data_out  (data_out),
        .ctrl_out  (ctrl_out),
        .de        (de),
        .locked    (locked),
        .bit_offset(bit_offset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [15:0] obs,
                         input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step(input logic [9:0] w);
        tmds_raw = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        tmds_raw = 10'h000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [9:0] tc, tp;
    logic [1:0] ca, cb;
    int         n;
    int         slip_at [4];
    logic [3:0] last_off;

    initial begin
        tests = 0;
        fails = 0;

        // Test 1: reset state, then constant 0x354 locks after 10 edges
        do_reset();
        check("rst_locked", 16'(locked), 16'd0);
        check("rst_de", 16'(de), 16'd0);
        check("rst_ctrl", 16'(ctrl_out), 16'd0);
        check("rst_data", 16'(data_out), 16'd0);
        check("rst_off", 16'(bit_offset), 16'd0);
        repeat (9) step(10'h354);
        check("t1_not_yet", 16'(locked), 16'd0);
        step(10'h354);
        check("t1_locked", 16'(locked), 16'd1);
        check("t1_off", 16'(bit_offset), 16'd0);
        check("t1_ctrl", 16'(ctrl_out), 16'd0);
        check("t1_de", 16'(de), 16'd0);

        // Test 3: data decode at offset 0
        step(10'h100);
        step(10'h0FF);
        step(10'h2FF);
        check("t3_de0", 16'(de), 16'd1);
        check("t3_d0", 16'(data_out), 16'h00);
        step(10'h354);
        check("t3_de1", 16'(de), 16'd1);
        check("t3_d1", 16'(data_out), 16'hFF);
        step(10'h354);
        check("t3_d2", 16'(data_out), 16'hFE);
        step(10'h354);
        check("t3_tok_de", 16'(de), 16'd0);
        check("t3_tok_ctrl", 16'(ctrl_out), 16'd0);
        check("t3_hold", 16'(data_out), 16'hFE);

        // Test 4: 128 data words drop lock, slip to offset 1, relock
        step(10'h354);
        step(10'h354);
        repeat (129) step(10'h100);
        check("t4_still", 16'(locked), 16'd1);
        step(10'h100);
        check("t4_drop", 16'(locked), 16'd0);
        check("t4_off", 16'(bit_offset), 16'd1);
        check("t4_de", 16'(de), 16'd0);
        n = 0;
        while (!locked && n < 100) begin
            step(10'h2A9);
            n++;
        end
        check("t4_relock", 16'(locked), 16'd1);
        check("t4_reoff", 16'(bit_offset), 16'd1);
        check("t4_rectrl", 16'(ctrl_out), 16'd0);

        // Test 2: alternating tokens rotated by 3 bits
        do_reset();
        tp = 10'h2AB;
        tc = 10'h354;
        n = 0;
        last_off = 4'd0;
        for (int i = 0; i < 4; i++) slip_at[i] = -1;
        while (!locked && n < 400) begin
            step({tc[6:0], tp[9:7]});
            n++;
            if (bit_offset != last_off && bit_offset < 4) begin
                slip_at[bit_offset] = n;
                last_off = bit_offset;
            end
            tp = tc;
            tc = (tc == 10'h354) ? 10'h2AB : 10'h354;
        end
        check("t2_slip1", 16'(slip_at[1]), 16'd64);
        check("t2_slip2", 16'(slip_at[2]), 16'd130);
        check("t2_slip3", 16'(slip_at[3]), 16'd196);
        check("t2_lock_at", 16'(n), 16'd206);
        check("t2_off", 16'(bit_offset), 16'd3);
        step({tc[6:0], tp[9:7]});
        ca = ctrl_out;
        tp = tc;
        tc = (tc == 10'h354) ? 10'h2AB : 10'h354;
        step({tc[6:0], tp[9:7]});
        cb = ctrl_out;
        check("t2_alt", 16'(ca ^ cb), 16'd3);
        check("t2_code", 16'(ca == 2'b00 || ca == 2'b11), 16'd1);
        check("t2_de", 16'(de), 16'd0);

        // Test 5: ten search timeouts walk offset 0..9 and wrap
        do_reset();
        repeat (63) step(10'h000);
        check("t5_off_pre", 16'(bit_offset), 16'd0);
        step(10'h000);
        check("t5_off1", 16'(bit_offset), 16'd1);
        for (int i = 2; i <= 10; i++) begin
            repeat (66) step(10'h000);
            check($sformatf("t5_off%0d", i % 10),
                  16'(bit_offset), 16'(i % 10));
            check("t5_nolock", 16'(locked), 16'd0);
        end

        // Test 6: async reset while locked, then relock
        do_reset();
        repeat (10) step(10'h354);
        check("t6_locked", 16'(locked), 16'd1);
        step(10'h0FF);
        step(10'h354);
        step(10'h354);
        check("t6_data", 16'(data_out), 16'hFF);
        rst_n = 1'b0;
        #1;
        check("t6_locked0", 16'(locked), 16'd0);
        check("t6_data0", 16'(data_out), 16'd0);
        check("t6_de0", 16'(de), 16'd0);
        check("t6_ctrl0", 16'(ctrl_out), 16'd0);
        check("t6_off0", 16'(bit_offset), 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (9) step(10'h354);
        check("t6_not_yet", 16'(locked), 16'd0);
        step(10'h354);
        check("t6_relock", 16'(locked), 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
